// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - two-port round-robin bus controller in front of a 16-bit word array
// Optional feature: define BUS_SNOOP_INVALIDATE_EN to publish write addresses as cross-port invalidates.
module bus_controller #(
  parameter int MEM_LATENCY   = 2,
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] req0,
  input  logic [24:0] req1,
  input  logic        req0_ready,
  input  logic        req1_ready,
  output logic [15:0] resp0,
  output logic [15:0] resp1,
  output logic        resp0_ready,
  output logic        resp1_ready,
  output logic [15:0] inval0,
  output logic [15:0] inval1,
  output logic        busy
);

  localparam int         DEPTH    = 1 << MEM_ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  count;
  logic        last_port;   // port served most recently; 1 after reset so port 0 wins first
  logic        gnt_port;
  logic        lat_wr;
  logic [7:0]  lat_data;
  logic [15:0] lat_addr;
  logic [15:0] mem [DEPTH];

  logic                     pick_port;
  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [15:0]              cur_word;
  logic [15:0]              new_word;
  logic                     gnt_ready;
  logic                     do_access;

  // Higher address bits are dropped so the array aliases
  assign word_idx  = lat_addr[MEM_ADDR_BITS:1];
  assign cur_word  = mem[word_idx];
  assign gnt_ready = gnt_port ? req1_ready : req0_ready;
  assign do_access = (state == ST_ACCESS) && (count == 4'd0);
  assign busy      = (state != ST_IDLE);

  // Round-robin pick: port 0 wins when alone or when port 1 was served last
  always_comb begin
    pick_port = 1'b1;
    if (req0_ready && (!req1_ready || last_port)) begin
      pick_port = 1'b0;
    end
  end

  // Post-access word: a write replaces only the byte lane chosen by address bit 0
  always_comb begin
    new_word = cur_word;
    if (lat_wr) begin
      if (lat_addr[0]) begin
        new_word[15:8] = lat_data;
      end else begin
        new_word[7:0] = lat_data;
      end
    end
  end

  // Backing store: cleared on reset, written only at the access point of a write
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[MEM_ADDR_BITS-1:0]] <= '0;
      end
    end else if (do_access && lat_wr) begin
      mem[word_idx] <= new_word;
    end
  end

  // Transaction FSM; the response word and strobe are registered on entry to
  // RESPOND so they are visible for exactly the RESPOND cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= 4'd0;
      last_port   <= 1'b1;
      gnt_port    <= 1'b0;
      lat_wr      <= 1'b0;
      lat_data    <= 8'h00;
      lat_addr    <= 16'h0000;
      resp0       <= 16'h0000;
      resp1       <= 16'h0000;
      resp0_ready <= 1'b0;
      resp1_ready <= 1'b0;
    end else begin
      resp0_ready <= 1'b0;
      resp1_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            gnt_port                     <= pick_port;
            last_port                    <= pick_port;
            {lat_wr, lat_data, lat_addr} <= pick_port ? req1 : req0;
            count                        <= CNT_LOAD;
            state                        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (count == 4'd0) begin
            if (gnt_port) begin
              resp1       <= new_word;
              resp1_ready <= 1'b1;
            end else begin
              resp0       <= new_word;
              resp0_ready <= 1'b1;
            end
            state <= ST_RESPOND;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_RESPOND: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!gnt_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BUS_SNOOP_INVALIDATE_EN
  // A write by one port publishes its address to the other port's invalidate bus
  always_ff @(posedge clock) begin
    if (!reset) begin
      inval0 <= 16'h0000;
      inval1 <= 16'h0000;
    end else if (do_access && lat_wr) begin
      if (gnt_port) begin
        inval0 <= lat_addr;
      end else begin
        inval1 <= lat_addr;
      end
    end
  end
`else
  assign inval0 = 16'h0000;
  assign inval1 = 16'h0000;

  logic unused_addr_bits;
  assign unused_addr_bits = ^lat_addr;
`endif

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - self-checking bench for bus_controller (vectors, corner sequences, random vs model)
module tb_bus_controller;

  localparam int LAT = 2;

`ifdef BUS_SNOOP_INVALIDATE_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [24:0] req0 = '0;
  logic [24:0] req1 = '0;
  logic        req0_ready = 1'b0;
  logic        req1_ready = 1'b0;
  logic [15:0] resp0;
  logic [15:0] resp1;
  logic        resp0_ready;
  logic        resp1_ready;
  logic [15:0] inval0;
  logic [15:0] inval1;
  logic        busy;

  always #5 clock = ~clock;

  bus_controller #(.MEM_LATENCY(LAT), .MEM_ADDR_BITS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .resp0       (resp0),
    .resp1       (resp1),
    .resp0_ready (resp0_ready),
    .resp1_ready (resp1_ready),
    .inval0      (inval0),
    .inval1      (inval1),
    .busy        (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: word array, last-served port, pending requests, visible outputs
  logic [15:0] m_mem [256];
  logic        m_last;
  bit          pend [2];
  logic [24:0] preq [2];
  logic [15:0] m_resp [2];
  logic [15:0] m_inval [2];

  typedef struct {
    bit          port;
    bit          wr;
    logic [7:0]  data;
    logic [15:0] addr;
    logic [15:0] exp_word;
    logic [15:0] exp_i0;
    logic [15:0] exp_i1;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    m_last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pend[p]    = 1'b0;
      m_resp[p]  = 16'h0000;
      m_inval[p] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0       = '0;
    req1       = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_resp0", resp0, 0);
    check("rst_resp1", resp1, 0);
    check("rst_strobes", {resp0_ready, resp1_ready}, 0);
    check("rst_inval0", inval0, 0);
    check("rst_inval1", inval1, 0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic raise(input int p, input bit wr, input logic [7:0] d, input logic [15:0] a);
    preq[p] = {wr, d, a};
    pend[p] = 1'b1;
    if (p == 0) begin
      req0       = {wr, d, a};
      req0_ready = 1'b1;
    end else begin
      req1       = {wr, d, a};
      req1_ready = 1'b1;
    end
  endtask

  // Waits for one response, checks it against the model, holds ready for 'hold'
  // extra cycles, drops it and waits for the controller to return to idle
  task automatic serve(input string tag, input int exp_lat, input int hold,
                       output int got_p, output logic [15:0] got_w);
    int          waited;
    int          exp_p;
    int          p;
    int          idx;
    int          n;
    logic [15:0] w;
    logic [24:0] r;
    waited = 0;
    got_p  = -1;
    got_w  = 16'h0000;
    exp_p  = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[0] ? 0 : 1);
    while (!(resp0_ready || resp1_ready) && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (!(resp0_ready || resp1_ready)) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no strobe after %0d cycles, required within 40", tag, waited);
      return;
    end
    check({tag, "_dual_strobe"}, resp0_ready & resp1_ready, 0);
    p = resp1_ready ? 1 : 0;
    check({tag, "_port"}, p, exp_p);
    if (exp_lat > 0) check({tag, "_latency"}, waited, exp_lat);
    r   = preq[p];
    idx = (r[15:0] / 2) % 256;
    w   = m_mem[idx];
    if (r[24]) begin
      if (r[0]) w = {r[23:16], w[7:0]};
      else      w = {w[15:8], r[23:16]};
    end
    m_mem[idx] = w;
    m_resp[p]  = w;
    m_last     = p[0];
    if (SNOOP && r[24]) m_inval[1 - p] = r[15:0];
    check({tag, "_resp0"}, resp0, m_resp[0]);
    check({tag, "_resp1"}, resp1, m_resp[1]);
    check({tag, "_inval0"}, inval0, m_inval[0]);
    check({tag, "_inval1"}, inval1, m_inval[1]);
    got_p = p;
    got_w = p ? resp1 : resp0;
    repeat (hold) begin
      @(negedge clock);
      check({tag, "_hold_busy"}, busy, 1);
      check({tag, "_hold_strobe"}, {resp0_ready, resp1_ready}, 0);
    end
    if (p == 0) req0_ready = 1'b0;
    else        req1_ready = 1'b0;
    pend[p] = 1'b0;
    @(negedge clock);
    check({tag, "_pulse"}, {resp0_ready, resp1_ready}, 0);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gp;
    logic [15:0] gw;
    int          order [4];
    int          choice;
    int          nserve;
    logic [15:0] a;

    tbl[0] = '{1'b0, 1'b0, 8'h00, 16'h0010, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 8'hAB, 16'h0011, 16'hAB00, 16'h0000, SNOOP ? 16'h0011 : 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 16'h0010, 16'hAB00, 16'h0000, SNOOP ? 16'h0011 : 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 8'h5A, 16'h0002, 16'h005A, 16'h0000, SNOOP ? 16'h0002 : 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 16'h0202, 16'h005A, 16'h0000, SNOOP ? 16'h0002 : 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 8'h12, 16'h0203, 16'h125A, SNOOP ? 16'h0203 : 16'h0000, SNOOP ? 16'h0002 : 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 16'h0003, 16'h125A, SNOOP ? 16'h0203 : 16'h0000, SNOOP ? 16'h0002 : 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 16'h0100, 16'h0000, SNOOP ? 16'h0203 : 16'h0000, SNOOP ? 16'h0002 : 16'h0000};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      raise(int'(tbl[i].port), tbl[i].wr, tbl[i].data, tbl[i].addr);
      serve($sformatf("tbl%0d", i), LAT + 1, 0, gp, gw);
      check($sformatf("tbl%0d_gport", i), gp, int'(tbl[i].port));
      check($sformatf("tbl%0d_word", i), gw, tbl[i].exp_word);
      check($sformatf("tbl%0d_i0", i), inval0, tbl[i].exp_i0);
      check($sformatf("tbl%0d_i1", i), inval1, tbl[i].exp_i1);
    end

    // Simultaneous reads twice: service order must alternate 0,1,0,1
    do_reset();
    for (int k = 0; k < 2; k++) begin
      raise(0, 1'b0, 8'h00, 16'h0010);
      raise(1, 1'b0, 8'h00, 16'h0020);
      serve("rr_a", LAT + 1, 0, gp, gw);
      order[2 * k] = gp;
      serve("rr_b", LAT + 1, 0, gp, gw);
      order[2 * k + 1] = gp;
    end
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);
    check("rr_order3", order[3], 1);

    // Granted port holds ready after its strobe; the other port must wait
    raise(0, 1'b0, 8'h00, 16'h0010);
    raise(1, 1'b0, 8'h00, 16'h0012);
    serve("hold_a", LAT + 1, 3, gp, gw);
    check("hold_a_gport", gp, 0);
    serve("hold_b", LAT + 1, 0, gp, gw);
    check("hold_b_gport", gp, 1);

    // Request changes after the grant edge are ignored
    raise(0, 1'b1, 8'h77, 16'h0020);
    @(negedge clock);
    req0 = {1'b1, 8'h99, 16'h0021};
    serve("latch", LAT, 0, gp, gw);
    check("latch_word", gw, 16'h0077);
    raise(1, 1'b0, 8'h00, 16'h0020);
    serve("latch_rd", LAT + 1, 0, gp, gw);
    check("latch_rd_word", gw, 16'h0077);

    // Reset at the access edge of a write aborts it
    raise(0, 1'b1, 8'hFF, 16'h0004);
    @(negedge clock);
    check("abort_strobe_a", {resp0_ready, resp1_ready}, 0);
    @(negedge clock);
    check("abort_strobe_b", {resp0_ready, resp1_ready}, 0);
    check("abort_busy", busy, 1);
    reset      = 1'b0;
    req0_ready = 1'b0;
    @(negedge clock);
    check("abort_strobe_c", {resp0_ready, resp1_ready}, 0);
    check("abort_busy_rst", busy, 0);
    reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      check("abort_strobe_d", {resp0_ready, resp1_ready}, 0);
    end
    raise(0, 1'b0, 8'h00, 16'h0004);
    serve("abort_rd", LAT + 1, 0, gp, gw);
    check("abort_rd_word", gw, 16'h0000);
    raise(1, 1'b0, 8'h00, 16'h0020);
    serve("clear_rd", LAT + 1, 0, gp, gw);
    check("clear_rd_word", gw, 16'h0000);

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 150; it++) begin
      choice = $urandom_range(0, 2);
      nserve = 0;
      for (int p = 0; p < 2; p++) begin
        if (choice == 2 || choice == p) begin
          a = 16'($urandom);
          if ($urandom_range(0, 1) == 1) a = a & 16'hF00F;
          raise(p, 1'($urandom), 8'($urandom), a);
          nserve++;
        end
      end
      repeat (nserve) serve("rnd", LAT + 1, $urandom_range(0, 2), gp, gw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
